// File: rtl/seg7_value_display.sv
// seg7_value_display: shows a DATA_WIDTH-bit value in hex or decimal on DIGITS
// active-low 7-segment displays, with leading-zero blanking, blink and an
// overflow (dash) indication. Decimal conversion is a sequential double-dabble.
module seg7_value_display #(
  parameter int DIGITS      = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BLINK_HZ    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  decimal,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic                  ready,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BCD_DIGITS  = (DATA_WIDTH + 2) / 3;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DIG_W       = 4 * DIGITS;
  localparam int PAD_W       = (DIG_W > BCD_W) ? DIG_W : BCD_W;
  localparam int BIT_W       = $clog2(DATA_WIDTH + 1);
  localparam int HALF_PERIOD = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Parameter sanity checks, reported while elaborating.
  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("seg7_value_display: DIGITS must be in 1..8");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 4 * DIGITS) begin : g_bad_width
      $error("seg7_value_display: DATA_WIDTH must satisfy 1 <= DATA_WIDTH <= 4*DIGITS");
    end
    if (HALF_PERIOD < 1) begin : g_bad_blink
      $error("seg7_value_display: CLK_FREQ_HZ/(2*BLINK_HZ) must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]      bcd, bcd_adj;
  logic [PAD_W-1:0]      bcd_pad;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  dec_mode;
  logic [DIG_W-1:0]      digit_reg, digits_next;
  logic                  ovf_next;
  logic                  shown;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [7*DIGITS-1:0]   hex_next;
  logic                  upper_zero;
  logic [3:0]            nib;

  // DE-board segment code for one hex digit (bit6=g .. bit0=a, active-low).
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0010000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: a decimal load runs DATA_WIDTH conversion cycles first.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (load) state_next = decimal ? CONVERT : UPDATE;
      CONVERT: if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Digit vector and overflow flag to be committed in UPDATE.
  always_comb begin
    bcd_pad  = PAD_W'(bcd);
    ovf_next = 1'b0;
    if (dec_mode) begin
      digits_next = bcd_pad[DIG_W-1:0];
      ovf_next    = |(bcd_pad >> DIG_W);
    end else begin
      digits_next = DIG_W'(shift_reg);
    end
  end

  // Capture on load, shift during CONVERT, commit digits/overflow in UPDATE.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      dec_mode  <= 1'b0;
      digit_reg <= '0;
      shown     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= value;
            bcd       <= '0;
            bit_cnt   <= '0;
            dec_mode  <= decimal;
          end
        end
        CONVERT: begin
          {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
          bit_cnt          <= bit_cnt + 1'b1;
        end
        UPDATE: begin
          digit_reg <= digits_next;
          overflow  <= ovf_next;
          shown     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Free-running blink timer; phase 1 means the display is blanked when blinking.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(HALF_PERIOD - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Per-digit segment selection, most significant digit first so blanking
  // knows whether every digit above is zero.
  always_comb begin
    hex_next   = {DIGITS{SEG_OFF}};
    upper_zero = 1'b1;
    nib        = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = digit_reg[4*i +: 4];
      if (nib != 4'd0) upper_zero = 1'b0;
      if (!enable || !shown || (blink && blink_phase))
        hex_next[7*i +: 7] = SEG_OFF;
      else if (overflow)
        hex_next[7*i +: 7] = SEG_DASH;
      else if (blank_lz && upper_zero && i != 0)
        hex_next[7*i +: 7] = SEG_OFF;
      else
        hex_next[7*i +: 7] = seg_code(nib);
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clock) begin
    if (reset) hex <= {DIGITS{SEG_OFF}};
    else       hex <= hex_next;
  end

endmodule

// File: tb/tb_seg7_value_display.sv
// Testbench for seg7_value_display: loads are scoreboarded and checked by a
// monitor when the DUT returns to ready; live controls are checked directly.
`timescale 1ns/1ps
module tb_seg7_value_display;

  localparam int OFF = 16;
  localparam int DSH = 17;

  logic        clock = 1'b0;
  logic        reset, enable, load6, load4, decimal, blank_lz, blink;
  logic [15:0] value;
  logic        ready6, ready4, ovf6, ovf4;
  logic [41:0] hex6;
  logic [27:0] hex4;

  always #5 clock = ~clock;

  seg7_value_display #(.DIGITS(6), .DATA_WIDTH(16), .CLK_FREQ_HZ(8), .BLINK_HZ(1)) dut6 (
    .clock(clock), .reset(reset), .enable(enable), .load(load6), .value(value),
    .decimal(decimal), .blank_lz(blank_lz), .blink(blink),
    .ready(ready6), .overflow(ovf6), .hex(hex6)
  );

  seg7_value_display #(.DIGITS(4), .DATA_WIDTH(16)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .load(load4), .value(value),
    .decimal(decimal), .blank_lz(blank_lz), .blink(blink),
    .ready(ready4), .overflow(ovf4), .hex(hex4)
  );

  typedef struct packed {
    logic [41:0] hex;
    logic        ovf;
    logic [7:0]  low;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  logic sel4 = 1'b0;
  logic pending = 1'b0;
  int   m_edges = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: code = 7'h40;  1: code = 7'h79;  2: code = 7'h24;  3: code = 7'h30;
      4: code = 7'h19;  5: code = 7'h12;  6: code = 7'h02;  7: code = 7'h78;
      8: code = 7'h00;  9: code = 7'h10;  10: code = 7'h08; 11: code = 7'h03;
      12: code = 7'h46; 13: code = 7'h21; 14: code = 7'h06; 15: code = 7'h0E;
      OFF: code = 7'h7F;
      default: code = 7'h3F;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int d5, d4, d3, d2, d1, d0);
    return {code(d5), code(d4), code(d3), code(d2), code(d1), code(d0)};
  endfunction

  function automatic exp_t mk(input logic [41:0] h, input logic o, input int low);
    exp_t e;
    e.hex = h;
    e.ovf = o;
    e.low = 8'(low);
    return e;
  endfunction

  // Non-reset edges since the last reset, used to predict the blink phase.
  always @(posedge clock) begin
    if (reset) m_edges <= 0;
    else       m_edges <= m_edges + 1;
  end

  // Monitor: a 0->1 transition of ready marks UPDATE; hex is checked one edge later.
  initial begin : monitor
    logic        r, o;
    logic [41:0] h;
    int          low_cnt, pend_low, n_txn;
    logic        prev_ready;
    exp_t        e;
    low_cnt = 0; pend_low = 0; n_txn = 0; prev_ready = 1'b1;
    forever begin
      @(negedge clock);
      r = sel4 ? ready4 : ready6;
      o = sel4 ? ovf4 : ovf6;
      h = sel4 ? {14'h3FFF, hex4} : hex6;
      if (reset) begin
        prev_ready = 1'b1;
        low_cnt    = 0;
        pending    = 1'b0;
      end else begin
        if (pending) begin
          pending = 1'b0;
          n_txn++;
          if (sb_q.size() == 0) begin
            check($sformatf("txn%0d_unexpected", n_txn), 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("txn%0d_hex", n_txn), 64'(h), 64'(e.hex));
            check($sformatf("txn%0d_overflow", n_txn), 64'(o), 64'(e.ovf));
            check($sformatf("txn%0d_ready_low", n_txn), 64'(pend_low), 64'(e.low));
          end
        end
        if (!r) low_cnt++;
        else if (!prev_ready) begin
          pending  = 1'b1;
          pend_low = low_cnt;
          low_cnt  = 0;
        end
        prev_ready = r;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic post(input logic to4, input logic [15:0] v, input logic dec, input exp_t e);
    value   = v;
    decimal = dec;
    if (to4) load4 = 1'b1;
    else     load6 = 1'b1;
    sb_q.push_back(e);
    tick(1);
    load4 = 1'b0;
    load6 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || pending) && n < 200) begin
      tick(1);
      n++;
    end
    check({name, "_drain"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [41:0] vis;
    reset = 1'b1; enable = 1'b1; load6 = 1'b0; load4 = 1'b0;
    decimal = 1'b0; blank_lz = 1'b0; blink = 1'b0; value = 16'h0;

    // Reset state, then no loads: display stays off.
    tick(2);
    check("rst_hex6", 64'(hex6), {22'h0, {6{7'h7F}}});
    check("rst_hex4", 64'(hex4), {36'h0, {4{7'h7F}}});
    check("rst_ready", 64'(ready6), 64'd1);
    check("rst_overflow", 64'(ovf6), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 9) check("idle_hex_off", 64'(hex6), {22'h0, {6{7'h7F}}});
    end

    // Hex load, then live leading-zero blanking.
    post(1'b0, 16'h02A5, 1'b0, mk(disp(0, 0, 0, 2, 10, 5), 1'b0, 1));
    wait_drain("hex_02a5");
    blank_lz = 1'b1;
    tick(1);
    check("blank_lz_live", 64'(hex6), 64'(disp(OFF, OFF, OFF, 2, 10, 5)));

    // Load held high re-triggers when ready returns.
    sb_q.push_back(mk(disp(OFF, OFF, OFF, OFF, 1, 1), 1'b0, 1));
    sb_q.push_back(mk(disp(OFF, OFF, OFF, OFF, 12, 0), 1'b0, 1));
    value = 16'h0011; decimal = 1'b0; load6 = 1'b1;
    tick(1);
    value = 16'h00C0;
    tick(2);
    load6 = 1'b0;
    wait_drain("held_load");

    // Decimal 65535; a load pulse and value change mid-conversion are ignored.
    post(1'b0, 16'd65535, 1'b1, mk(disp(OFF, 6, 5, 5, 3, 5), 1'b0, 17));
    tick(3);
    value = 16'h0000; decimal = 1'b0; load6 = 1'b1;
    tick(1);
    load6 = 1'b0; value = 16'h1234;
    wait_drain("dec_65535");

    // Four-digit instance: overflow, hex clears it, decimal zero with blanking.
    sel4 = 1'b1;
    blank_lz = 1'b0;
    post(1'b1, 16'd12345, 1'b1, mk(disp(OFF, OFF, DSH, DSH, DSH, DSH), 1'b1, 17));
    wait_drain("d4_dec_12345");
    post(1'b1, 16'h1234, 1'b0, mk(disp(OFF, OFF, 1, 2, 3, 4), 1'b0, 1));
    wait_drain("d4_hex_1234");
    blank_lz = 1'b1;
    post(1'b1, 16'd0, 1'b1, mk(disp(OFF, OFF, OFF, OFF, OFF, 0), 1'b0, 17));
    wait_drain("d4_dec_0");
    sel4 = 1'b0;

    // Blink with a 4-cycle half period, then steady, then enable off/on.
    blank_lz = 1'b0;
    vis = disp(0, 0, 0, 0, 15, 15);
    post(1'b0, 16'h00FF, 1'b0, mk(vis, 1'b0, 1));
    wait_drain("hex_00ff");
    blink = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check($sformatf("blink_c%0d", i), 64'(hex6),
            64'((((m_edges - 1) / 4) % 2 == 1) ? {6{7'h7F}} : vis));
    end
    blink = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("steady_c%0d", i), 64'(hex6), 64'(vis));
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("disabled_c%0d", i), 64'(hex6), {22'h0, {6{7'h7F}}});
    end
    enable = 1'b1;
    tick(1);
    check("reenabled", 64'(hex6), 64'(vis));

    // Reset during conversion cycle 5 of decimal 999, then a hex load.
    value = 16'd999; decimal = 1'b1; load6 = 1'b1;
    tick(1);
    load6 = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("abort_ready", 64'(ready6), 64'd1);
    check("abort_hex_off", 64'(hex6), {22'h0, {6{7'h7F}}});
    check("abort_overflow", 64'(ovf6), 64'd0);
    tick(1);
    reset = 1'b0;
    post(1'b0, 16'h0007, 1'b0, mk(disp(0, 0, 0, 0, 0, 7), 1'b0, 1));
    wait_drain("hex_0007");

    tick(2);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg7_value_display.md
Name: seg7_value_display

Overview:
- Parametrised successor of the fixed two-digit R16 hex readout; drives DIGITS active-low 7-segment displays from a DATA_WIDTH-bit value.
- Shows the value in hexadecimal or decimal. Decimal uses a sequential double-dabble converter.
- Adds leading-zero blanking, a blink mode and an overflow indication.
- Sits between CPU register/IO outputs and the board HEX pins. Uses a ready/load handshake so the CPU side can post values.

Parameters:
- DIGITS, 6, number of 7-segment displays driven (1..8).
- DATA_WIDTH, 16, width of value; must satisfy DATA_WIDTH <= 4*DIGITS, enforced by an elaboration-time check.
- CLK_FREQ_HZ, 50000000, clock frequency.
- BLINK_HZ, 2, blink rate; must give CLK_FREQ_HZ/(2*BLINK_HZ) >= 1.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 = all digits OFF; stored value and conversion state are retained.
- load  in  1  capture value/decimal when ready=1; ignored otherwise.
- value  in  DATA_WIDTH  unsigned value to display.
- decimal  in  1  0 = hex, 1 = decimal; sampled with load.
- blank_lz  in  1  level input: blank leading zeros.
- blink  in  1  level input: blink whole display.
- ready  out  1  converter idle, load accepted.
- overflow  out  1  last decimal value needs more than DIGITS digits.
- hex  out  7*DIGITS  segments, active-low, bit6=g..bit0=a; digit i at hex[7*i+6:7*i]; digit 0 is least significant.

Behaviour:
- Reset is synchronous, active-high, on clock. Reset values: hex = all 7'b1111111, ready=1, overflow=0, state IDLE, blink counter 0, blink phase 0 (visible), shown flag 0.
- hex stays OFF until the first completed load.
- Segment codes:
  - 0-9 and A-F use standard DE-board codes (e.g. 0=1000000, A=0001000, F=0001110).
  - OFF=1111111.
  - Dash=0111111.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE: ready=1. On load, capture value and decimal. decimal=0 goes to UPDATE; decimal=1 goes to CONVERT with the shift register seeded with value and BCD cleared. ready=0 from the next cycle.
  - CONVERT: exactly DATA_WIDTH cycles. Each cycle, add 3 to every BCD digit >= 5, then shift left one bit. Internal BCD holds ceil(DATA_WIDTH/3) digits. After the last shift, go to UPDATE.
  - UPDATE: one cycle. Write the digit register (nibbles zero-extended in hex mode, BCD digits in decimal mode). Set shown=1, update overflow, go to IDLE, ready=1.
- Overflow: set when decimal mode and any BCD digit at index >= DIGITS is nonzero. While set, all digits show Dash. The next hex load, or a decimal load that fits, clears it.
- Latency, with load accepted at edge k:
  - Hex mode: UPDATE at edge k+1; hex valid after edge k+2; ready low for exactly 1 cycle.
  - Decimal mode: UPDATE at edge k+DATA_WIDTH+1; hex valid after edge k+DATA_WIDTH+2; ready low for DATA_WIDTH+1 cycles.
- The hex output is registered. Each clock it evaluates, in priority order:
  - reset gives OFF;
  - enable=0 or shown=0 gives OFF;
  - blink=1 with phase=1 gives OFF;
  - overflow gives Dash;
  - otherwise the digit code.
- Leading-zero blanking: when blank_lz=1, digits above the most significant nonzero digit are OFF. Digit 0 is always shown, so value 0 displays "0". blank_lz is applied live and does not need a reload.
- Blink timer: free-running counter. Phase toggles every CLK_FREQ_HZ/(2*BLINK_HZ) cycles. It runs regardless of the blink input.
- Boundary conditions:
  - load while ready=0 is dropped with no side effects.
  - load held high re-triggers each time ready returns to 1.
  - Reset mid-CONVERT aborts the conversion. Next cycle: IDLE, ready=1, hex OFF.
  - value changing during CONVERT has no effect, because the value was captured at load.

Test Plan:
1. Reset held 2 cycles, then released -> hex=all 7'h7F, ready=1, overflow=0. load=0 for 10 cycles -> hex stays OFF.
2. DIGITS=6, DATA_WIDTH=16: load 16'h02A5, decimal=0, blank_lz=0 -> ready=0 for 1 cycle. hex5..hex0 = 0,0,0,2,A,5 exactly 2 edges after load. Then blank_lz=1 -> OFF,OFF,OFF,2,A,5 on the next edge.
3. Load 16'd65535, decimal=1, blank_lz=1 -> ready=0 for 17 cycles. hex = OFF,6,5,5,3,5 at edge k+18; overflow=0. A load pulse during conversion is ignored.
4. DIGITS=4, DATA_WIDTH=16:
   - decimal load 16'd12345 -> overflow=1, all four digits Dash.
   - hex load 16'h1234 -> overflow=0, shows 1,2,3,4.
   - decimal load 0 with blank_lz=1 -> OFF,OFF,OFF,0.
5. CLK_FREQ_HZ=8, BLINK_HZ=1, blink=1, value 16'h00FF shown -> digits alternate visible/OFF every 4 cycles. blink=0 -> always visible. enable=0 -> OFF, and value is restored when enable returns to 1.
6. Reset asserted at conversion cycle 5 of decimal 16'd999 -> next cycle ready=1, hex OFF. A following hex load 16'h0007 -> 0,0,0,0,0,7 with correct latency.
